// File: rtl/mem_arb_pkg.sv
// Shared types and constants for the instruction/data memory arbiter.
// Holds the read-owner encoding and the statistics counter width.
package mem_arb_pkg;

  typedef enum logic [1:0] {
    OWN_NONE = 2'd0,
    OWN_I    = 2'd1,
    OWN_D    = 2'd2
  } owner_e;

  localparam int STAT_W = 16;

endpackage

// File: rtl/mem_arb_starve_cnt.sv
// Saturating fetch-starvation counter: counts up on inc, clears on clr.
// Ports: clk, reset, inc, clr in; at_max out (count equals MAX).
module mem_arb_starve_cnt #(
  parameter int MAX = 4
) (
  input  logic clk,
  input  logic reset,
  input  logic inc,
  input  logic clr,
  output logic at_max
);

  localparam int W = (MAX < 2) ? 1 : $clog2(MAX + 1);

  logic [W-1:0] cnt;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cnt <= '0;
    end else if (clr) begin
      cnt <= '0;
    end else if (inc && (cnt != W'(MAX))) begin
      cnt <= cnt + 1'b1;
    end
  end

  assign at_max = (cnt == W'(MAX));

endmodule

// File: rtl/mem_arbiter.sv
// Arbitrates one single-port synchronous memory between fetch and data ports.
// Data wins unless fetch has been denied MAX_WAIT cycles in a row; responses
// are steered back one cycle after the grant using a read-owner register.
// Ports: clk, reset; i_* fetch port; d_* data port; mem_* shared memory.
// Optional: MEM_ARB_STATS_EN adds i_gnt_cnt, d_gnt_cnt, stall_cnt outputs.
module mem_arbiter
  import mem_arb_pkg::*;
#(
  parameter int WIDTH    = 32,
  parameter int ADDR     = 5,
  parameter int MAX_WAIT = 4
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             i_req,
  input  logic [ADDR-1:0]  i_addr,
  output logic             i_gnt,
  output logic             i_rvalid,
  output logic [WIDTH-1:0] i_rdata,
  input  logic             d_req,
  input  logic             d_we,
  input  logic [ADDR-1:0]  d_addr,
  input  logic [WIDTH-1:0] d_wdata,
  output logic             d_gnt,
  output logic             d_rvalid,
  output logic [WIDTH-1:0] d_rdata,
  output logic [ADDR-1:0]  mem_addr,
  output logic             mem_wr_en,
  output logic [WIDTH-1:0] mem_wdata,
`ifdef MEM_ARB_STATS_EN
  output logic [STAT_W-1:0] i_gnt_cnt,
  output logic [STAT_W-1:0] d_gnt_cnt,
  output logic [STAT_W-1:0] stall_cnt,
`endif
  input  logic [WIDTH-1:0] mem_rdata
);

  logic       starved;
  owner_e     owner;
  owner_e     owner_nxt;
  logic [WIDTH-1:0] i_hold;
  logic [WIDTH-1:0] d_hold;

  mem_arb_starve_cnt #(
    .MAX (MAX_WAIT)
  ) u_starve (
    .clk    (clk),
    .reset  (reset),
    .inc    (i_req & ~i_gnt),
    .clr    (~i_req | i_gnt),
    .at_max (starved)
  );

  // Grants are forced low while reset is asserted.
  always_comb begin
    i_gnt = 1'b0;
    d_gnt = 1'b0;
    if (!reset) begin
      i_gnt = i_req & (~d_req | starved);
      d_gnt = d_req & ~i_gnt;
    end
  end

  always_comb begin
    mem_addr  = '0;
    mem_wr_en = d_gnt & d_we;
    mem_wdata = d_wdata;
    if (i_gnt) begin
      mem_addr = i_addr;
    end else if (d_gnt) begin
      mem_addr = d_addr;
    end
  end

  always_comb begin
    owner_nxt = OWN_NONE;
    if (i_gnt) begin
      owner_nxt = OWN_I;
    end else if (d_gnt && !d_we) begin
      owner_nxt = OWN_D;
    end
  end

  // Hold registers keep each port's last returned word while not owner.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      owner  <= OWN_NONE;
      i_hold <= '0;
      d_hold <= '0;
    end else begin
      owner <= owner_nxt;
      if (owner == OWN_I) begin
        i_hold <= mem_rdata;
      end
      if (owner == OWN_D) begin
        d_hold <= mem_rdata;
      end
    end
  end

  assign i_rvalid = (owner == OWN_I);
  assign d_rvalid = (owner == OWN_D);
  assign i_rdata  = i_rvalid ? mem_rdata : i_hold;
  assign d_rdata  = d_rvalid ? mem_rdata : d_hold;

`ifdef MEM_ARB_STATS_EN
  localparam logic [STAT_W-1:0] SAT = '1;

  logic stall;

  assign stall = (i_req & ~i_gnt) | (d_req & ~d_gnt);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      i_gnt_cnt <= '0;
      d_gnt_cnt <= '0;
      stall_cnt <= '0;
    end else begin
      if (i_gnt && (i_gnt_cnt != SAT)) begin
        i_gnt_cnt <= i_gnt_cnt + 1'b1;
      end
      if (d_gnt && (d_gnt_cnt != SAT)) begin
        d_gnt_cnt <= d_gnt_cnt + 1'b1;
      end
      if (stall && (stall_cnt != SAT)) begin
        stall_cnt <= stall_cnt + 1'b1;
      end
    end
  end
`endif

endmodule
